psum_output_buffer: RTL and testbench
=====================================

Name: psum_output_buffer

Overview:
- Parametrised successor to the per-lane output register-file bank. Sits between the PE array and the writeback/DMA path.
- LANES independent register files, DEPTH entries each, RD_PORTS combinational read ports per lane.
- Write port supports overwrite or saturating signed accumulate of partial sums.
- A drain FSM streams whole rows (one entry index across all lanes) out over a valid/ready handshake, optionally clearing each entry as it leaves.

Parameters:
LANES, 32, number of independent lanes / register files
DEPTH, 32, entries per lane (power of two, >=2)
DATA_W, 8, entry width, signed two's complement
RD_PORTS, 4, combinational read ports per lane
ADDR_W, $clog2(DEPTH), address width (derived; not overridden)

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
wr_en  in  [LANES]  per-lane write strobe
wr_mode  in  1  global; 0 = overwrite, 1 = saturating accumulate
wr_addr  in  [LANES][ADDR_W]  per-lane write address
wr_data  in  [LANES][DATA_W]  per-lane write data
rd_addr  in  [LANES][RD_PORTS][ADDR_W]  per-lane, per-port read address
rd_data  out  [LANES][RD_PORTS][DATA_W]  combinational read data
drain_start  in  1  pulse; begin drain of all DEPTH rows
drain_clear  in  1  sampled with drain_start; zero each entry after it is handed off
drain_valid  out  1  drain row valid
drain_ready  in  1  downstream accepts row
drain_idx  out  [ADDR_W]  index of the current drain row
drain_data  out  [LANES][DATA_W]  current drain row
busy  out  1  high while drain is in progress
drain_done  out  1  one-cycle pulse after the last row is accepted
sat_flag  out  [LANES]  sticky per-lane flag: an accumulate saturated

Behaviour:
- Reset (nrst low, async):
  - all entries = 0; sat_flag = 0
  - FSM = IDLE; busy = 0, drain_valid = 0, drain_done = 0
  - drain_idx = 0; the stored clear flag = 0
- Writes occur on the rising edge when wr_en[i] = 1 and the FSM is IDLE.
  - Overwrite: mem[i][wr_addr[i]] <= wr_data[i].
  - Accumulate: mem <= sat(mem + wr_data), computed at DATA_W+1 bits and clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. On a clamp, sat_flag[i] <= 1.
  - sat_flag clears only on reset or on drain_start.
- Writes while busy = 1 are ignored with no side effects. Upstream must gate on busy.
- Reads are combinational with no latency: rd_data[i][p] = mem[i][rd_addr[i][p]].
  - Same-cycle read of an address being written returns the old value; the new value is visible the next cycle.
- Drain FSM states: IDLE, DRAIN, DONE.
  - IDLE -> DRAIN on drain_start (ignored outside IDLE). Latch drain_clear, set drain_idx = 0, clear sat_flag.
  - DRAIN: drain_valid = 1, busy = 1, drain_data[i] = mem[i][drain_idx]. drain_data/drain_idx are held stable while drain_valid && !drain_ready.
  - On drain_valid && drain_ready: if clear is latched, mem[*][drain_idx] <= 0. Then, if drain_idx == DEPTH-1, go to DONE; otherwise drain_idx++.
  - DONE: drain_done = 1 for one cycle, busy = 0, drain_valid = 0, drain_idx returns to 0. Unconditional transition to IDLE.
- Total drain time with drain_ready held high: DEPTH+1 cycles from the drain_start edge through the drain_done pulse.
- drain_start and wr_en in the same IDLE cycle: the write commits, then the drain begins next cycle and sees the written value.
- Reset mid-drain: immediate return to IDLE with memory zeroed. No drain_done pulse.
- Out-of-range addresses cannot occur, since DEPTH is a power of two.

Decomposition:
- Package psum_buf_pkg holds:
  - typedef enum wr_mode_e {WR_OVERWRITE, WR_ACCUM}
  - typedef enum drain_state_e {IDLE, DRAIN, DONE}
  - function sat_add(a, b) parametrised by DATA_W
- Sub-module psum_lane_rf: one lane. Contains DEPTH x DATA_W storage, RD_PORTS read muxes, overwrite/accumulate write logic, a drain read port, a clear-on-drain port and the sat flag.
- The top module generates LANES instances plus a single shared drain FSM.

Test Plan:
- Overwrite lane 3, addr 5, with 0x12. Next cycle, all 4 read ports at addr 5 -> 0x12. A same-cycle read during the write -> old value 0x00.
- Accumulate lane 0, addr 1: write 100, then +20 -> stored 120, sat_flag[0] = 0. Then +20 -> 127, sat_flag[0] = 1. Separately, -100 then +(-50) -> -128.
- Fill row k with value k+1 in every lane, then drain_start with drain_ready = 1 -> rows 0..31 appear on consecutive cycles with drain_idx = k. drain_done pulses on cycle 33.
- Drain with drain_ready toggling 1,0,1,0 -> each row is held stable while ready = 0, with no skipped or repeated indices. 32 accepts total.
- drain_clear = 1 drain, then a read of every address -> all 0. Writes issued mid-drain (busy = 1) -> memory unchanged.
- Assert nrst during row 10 of a drain -> busy = 0, drain_valid = 0 and memory = 0 immediately. No drain_done pulse. A fresh drain_start works normally.

Source files
------------

// File: rtl/psum_buf_pkg.sv
// Shared types and the saturating-add helper for the partial-sum output buffer.
// sat_add works on sign-extended 32-bit operands and clamps to a data_w-bit signed range (data_w <= 31).
package psum_buf_pkg;

   typedef enum logic {
      WR_OVERWRITE = 1'b0,
      WR_ACCUM     = 1'b1
   } wr_mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } drain_state_e;

   typedef struct packed {
      logic               sat;
      logic signed [31:0] val;
   } sat_res_t;

   function automatic sat_res_t sat_add(input logic signed [31:0] a,
                                        input logic signed [31:0] b,
                                        input int                 data_w);
      logic signed [31:0] sum;
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      sat_res_t           r;
      sum   = a + b;
      hi    = (32'sd1 <<< (data_w - 1)) - 32'sd1;
      lo    = -(32'sd1 <<< (data_w - 1));
      r.sat = 1'b0;
      r.val = sum;
      if (sum > hi) begin
         r.val = hi;
         r.sat = 1'b1;
      end else if (sum < lo) begin
         r.val = lo;
         r.sat = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/psum_lane_rf.sv
// One lane of the partial-sum buffer: DEPTH x DATA_W storage, combinational read ports,
// overwrite / saturating-accumulate write, drain read port with clear, sticky saturation flag.
module psum_lane_rf
   import psum_buf_pkg::*;
#(
   parameter int DEPTH    = 32,
   parameter int DATA_W   = 8,
   parameter int RD_PORTS = 4,
   parameter int ADDR_W   = $clog2(DEPTH)
) (
   input  logic                              clk_i,
   input  logic                              nrst_i,
   input  logic                              wr_en_i,
   input  logic                              wr_mode_i,
   input  logic [ADDR_W-1:0]                 wr_addr_i,
   input  logic [DATA_W-1:0]                 wr_data_i,
   input  logic [RD_PORTS-1:0][ADDR_W-1:0]   rd_addr_i,
   output logic [RD_PORTS-1:0][DATA_W-1:0]   rd_data_o,
   input  logic [ADDR_W-1:0]                 drain_idx_i,
   output logic [DATA_W-1:0]                 drain_data_o,
   input  logic                              clr_en_i,
   input  logic                              sat_clr_i,
   output logic                              sat_flag_o
);

   logic [DEPTH-1:0][DATA_W-1:0] mem_q;
   logic [DEPTH-1:0][DATA_W-1:0] mem_d;
   logic                         sat_q;
   logic                         sat_d;
   sat_res_t                     acc_res;
   logic                         unused_acc_hi;

   always_comb begin
      acc_res = sat_add(32'(signed'(mem_q[wr_addr_i])), 32'(signed'(wr_data_i)), DATA_W);
   end

   assign unused_acc_hi = ^acc_res.val[31:DATA_W];

   // Writes only arrive while idle and clears only while draining, so they never collide.
   // A drain start clears the flag before a same-cycle accumulate can set it again.
   always_comb begin
      mem_d = mem_q;
      sat_d = sat_q;
      if (sat_clr_i) begin
         sat_d = 1'b0;
      end
      if (wr_en_i) begin
         if (wr_mode_i == logic'(WR_ACCUM)) begin
            mem_d[wr_addr_i] = acc_res.val[DATA_W-1:0];
            if (acc_res.sat) begin
               sat_d = 1'b1;
            end
         end else begin
            mem_d[wr_addr_i] = wr_data_i;
         end
      end
      if (clr_en_i) begin
         mem_d[drain_idx_i] = '0;
      end
   end

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         mem_q <= '0;
         sat_q <= 1'b0;
      end else begin
         mem_q <= mem_d;
         sat_q <= sat_d;
      end
   end

   always_comb begin
      rd_data_o = '0;
      for (int p = 0; p < RD_PORTS; p++) begin
         rd_data_o[p] = mem_q[rd_addr_i[p]];
      end
   end

   assign drain_data_o = mem_q[drain_idx_i];
   assign sat_flag_o   = sat_q;

endmodule

// File: rtl/psum_output_buffer.sv
// Partial-sum output buffer: LANES register-file lanes plus one shared row-drain FSM.
//   state | meaning
//   IDLE  | accepts writes, waits for drain_start_i
//   DRAIN | presents row idx_q on the valid/ready handshake, writes blocked
//   DONE  | one-cycle drain_done_o pulse, then back to IDLE
module psum_output_buffer
   import psum_buf_pkg::*;
#(
   parameter int  LANES    = 32,
   parameter int  DEPTH    = 32,
   parameter int  DATA_W   = 8,
   parameter int  RD_PORTS = 4,
   localparam int ADDR_W   = $clog2(DEPTH)
) (
   input  logic                                        clk_i,
   input  logic                                        nrst_i,
   input  logic [LANES-1:0]                            wr_en_i,
   input  logic                                        wr_mode_i,
   input  logic [LANES-1:0][ADDR_W-1:0]                wr_addr_i,
   input  logic [LANES-1:0][DATA_W-1:0]                wr_data_i,
   input  logic [LANES-1:0][RD_PORTS-1:0][ADDR_W-1:0]  rd_addr_i,
   output logic [LANES-1:0][RD_PORTS-1:0][DATA_W-1:0]  rd_data_o,
   input  logic                                        drain_start_i,
   input  logic                                        drain_clear_i,
   output logic                                        drain_valid_o,
   input  logic                                        drain_ready_i,
   output logic [ADDR_W-1:0]                           drain_idx_o,
   output logic [LANES-1:0][DATA_W-1:0]                drain_data_o,
   output logic                                        busy_o,
   output logic                                        drain_done_o,
   output logic [LANES-1:0]                            sat_flag_o
);

   drain_state_e      state_q;
   drain_state_e      state_d;
   logic [ADDR_W-1:0] idx_q;
   logic [ADDR_W-1:0] idx_d;
   logic              clr_q;
   logic              clr_d;
   logic              accept;
   logic              idle;
   logic              sat_clr;

   assign idle    = (state_q == IDLE);
   assign sat_clr = idle && drain_start_i;

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      clr_d         = clr_q;
      accept        = 1'b0;
      busy_o        = 1'b0;
      drain_valid_o = 1'b0;
      drain_done_o  = 1'b0;
      case (state_q)
         IDLE: begin
            if (drain_start_i) begin
               state_d = DRAIN;
               idx_d   = '0;
               clr_d   = drain_clear_i;
            end
         end
         DRAIN: begin
            busy_o        = 1'b1;
            drain_valid_o = 1'b1;
            if (drain_ready_i) begin
               accept = 1'b1;
               if (idx_q == ADDR_W'(DEPTH - 1)) begin
                  state_d = DONE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + ADDR_W'(1);
               end
            end
         end
         DONE: begin
            drain_done_o = 1'b1;
            idx_d        = '0;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         state_q <= IDLE;
         idx_q   <= '0;
         clr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         clr_q   <= clr_d;
      end
   end

   assign drain_idx_o = idx_q;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      psum_lane_rf #(
         .DEPTH    (DEPTH),
         .DATA_W   (DATA_W),
         .RD_PORTS (RD_PORTS),
         .ADDR_W   (ADDR_W)
      ) u_lane (
         .clk_i        (clk_i),
         .nrst_i       (nrst_i),
         .wr_en_i      (wr_en_i[l] && idle),
         .wr_mode_i    (wr_mode_i),
         .wr_addr_i    (wr_addr_i[l]),
         .wr_data_i    (wr_data_i[l]),
         .rd_addr_i    (rd_addr_i[l]),
         .rd_data_o    (rd_data_o[l]),
         .drain_idx_i  (idx_q),
         .drain_data_o (drain_data_o[l]),
         .clr_en_i     (accept && clr_q),
         .sat_clr_i    (sat_clr),
         .sat_flag_o   (sat_flag_o[l])
      );
   end

endmodule

// File: tb/tb_psum_output_buffer.sv
// Bench for psum_output_buffer: directed vector table, randomized traffic against an
// array-based reference model, and hand-written drain / reset sequences.
module tb_psum_output_buffer;

   localparam int LANES    = 32;
   localparam int DEPTH    = 32;
   localparam int DATA_W   = 8;
   localparam int RD_PORTS = 4;
   localparam int ADDR_W   = 5;

   logic                                        clk;
   logic                                        nrst;
   logic [LANES-1:0]                            wr_en;
   logic                                        wr_mode;
   logic [LANES-1:0][ADDR_W-1:0]                wr_addr;
   logic [LANES-1:0][DATA_W-1:0]                wr_data;
   logic [LANES-1:0][RD_PORTS-1:0][ADDR_W-1:0]  rd_addr;
   logic [LANES-1:0][RD_PORTS-1:0][DATA_W-1:0]  rd_data;
   logic                                        drain_start;
   logic                                        drain_clear;
   logic                                        drain_valid;
   logic                                        drain_ready;
   logic [ADDR_W-1:0]                           drain_idx;
   logic [LANES-1:0][DATA_W-1:0]                drain_data;
   logic                                        busy;
   logic                                        drain_done;
   logic [LANES-1:0]                            sat_flag;

   psum_output_buffer #(
      .LANES    (LANES),
      .DEPTH    (DEPTH),
      .DATA_W   (DATA_W),
      .RD_PORTS (RD_PORTS)
   ) dut (
      .clk_i         (clk),
      .nrst_i        (nrst),
      .wr_en_i       (wr_en),
      .wr_mode_i     (wr_mode),
      .wr_addr_i     (wr_addr),
      .wr_data_i     (wr_data),
      .rd_addr_i     (rd_addr),
      .rd_data_o     (rd_data),
      .drain_start_i (drain_start),
      .drain_clear_i (drain_clear),
      .drain_valid_o (drain_valid),
      .drain_ready_i (drain_ready),
      .drain_idx_o   (drain_idx),
      .drain_data_o  (drain_data),
      .busy_o        (busy),
      .drain_done_o  (drain_done),
      .sat_flag_o    (sat_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int model[LANES][DEPTH];
   bit msat[LANES];

   typedef struct {
      int lane;
      bit acc;
      int addr;
      int data;
      int exp_val;
      bit exp_sat;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_write(input int l, input bit acc, input int a, input int d);
      int s;
      if (acc) begin
         s = model[l][a] + d;
         if (s > 127) begin
            s = 127;
            msat[l] = 1'b1;
         end else if (s < -128) begin
            s = -128;
            msat[l] = 1'b1;
         end
         model[l][a] = s;
      end else begin
         model[l][a] = d;
      end
   endfunction

   function automatic void model_reset();
      for (int l = 0; l < LANES; l++) begin
         msat[l] = 1'b0;
         for (int a = 0; a < DEPTH; a++) model[l][a] = 0;
      end
   endfunction

   task automatic check_all_mem(input string tag);
      for (int g = 0; g < DEPTH / RD_PORTS; g++) begin
         for (int l = 0; l < LANES; l++)
            for (int p = 0; p < RD_PORTS; p++)
               rd_addr[l][p] = ADDR_W'(g * RD_PORTS + p);
         #1;
         for (int l = 0; l < LANES; l++)
            for (int p = 0; p < RD_PORTS; p++)
               chk(tag, int'($signed(rd_data[l][p])), model[l][g * RD_PORTS + p]);
      end
   endtask

   task automatic check_sat(input string tag);
      for (int l = 0; l < LANES; l++) chk(tag, int'(sat_flag[l]), int'(msat[l]));
   endtask

   task automatic fill_rows(input int offset);
      wr_mode = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         wr_en = '1;
         for (int l = 0; l < LANES; l++) begin
            wr_addr[l] = ADDR_W'(k);
            wr_data[l] = DATA_W'(k + 1 + offset);
            model_write(l, 1'b0, k, k + 1 + offset);
         end
         tick();
      end
      wr_en = '0;
   endtask

   function automatic bit next_ready(input int rmode, input int n);
      if (rmode == 0) return 1'b1;
      if (rmode == 1) return (n % 2) == 1;
      return 1'($urandom_range(0, 1));
   endfunction

   // Caller drives any same-cycle write (and updates the model) before calling.
   task automatic run_drain(input bit clr, input int rmode, input bit junk, input string tag);
      int  k = 0;
      int  n = 0;
      bit  done_seen = 1'b0;
      bit  rdy;
      drain_start = 1'b1;
      drain_clear = clr;
      drain_ready = 1'b1;
      for (int l = 0; l < LANES; l++) msat[l] = 1'b0;
      tick();
      drain_start = 1'b0;
      drain_clear = 1'b0;
      wr_en       = '0;
      while (!done_seen && n < 4 * DEPTH + 8) begin
         n++;
         if (drain_done) begin
            done_seen = 1'b1;
            chk({tag, " done busy"}, int'(busy), 0);
            chk({tag, " done valid"}, int'(drain_valid), 0);
            chk({tag, " done idx"}, int'(drain_idx), 0);
            chk({tag, " accepts"}, k, DEPTH);
            if (rmode == 0) chk({tag, " done cycle"}, n, DEPTH + 1);
         end else begin
            chk({tag, " valid"}, int'(drain_valid), 1);
            chk({tag, " busy"}, int'(busy), 1);
            chk({tag, " idx"}, int'(drain_idx), k);
            if (k < DEPTH)
               for (int l = 0; l < LANES; l++)
                  chk({tag, " data"}, int'($signed(drain_data[l])), model[l][k]);
            rdy = next_ready(rmode, n);
            drain_ready = rdy;
            if (rdy) begin
               if (clr && k < DEPTH)
                  for (int l = 0; l < LANES; l++) model[l][k] = 0;
               k++;
            end
            if (junk) begin
               wr_en   = LANES'($urandom);
               wr_mode = 1'($urandom_range(0, 1));
               for (int l = 0; l < LANES; l++) begin
                  wr_addr[l] = ADDR_W'($urandom_range(0, DEPTH - 1));
                  wr_data[l] = DATA_W'($urandom);
               end
            end
            tick();
         end
      end
      wr_en       = '0;
      drain_ready = 1'b0;
      if (!done_seen) chk({tag, " timeout waiting for drain_done"}, 0, 1);
      tick();
      chk({tag, " done pulse width"}, int'(drain_done), 0);
      chk({tag, " idle busy"}, int'(busy), 0);
   endtask

   initial begin
      int l;
      int d;
      bit acc;
      bit hit;

      vecs[0] = '{lane: 3, acc: 1'b0, addr: 5, data: 'h12, exp_val: 'h12, exp_sat: 1'b0};
      vecs[1] = '{lane: 0, acc: 1'b0, addr: 1, data: 100,  exp_val: 100,  exp_sat: 1'b0};
      vecs[2] = '{lane: 0, acc: 1'b1, addr: 1, data: 20,   exp_val: 120,  exp_sat: 1'b0};
      vecs[3] = '{lane: 0, acc: 1'b1, addr: 1, data: 20,   exp_val: 127,  exp_sat: 1'b1};
      vecs[4] = '{lane: 1, acc: 1'b0, addr: 2, data: -100, exp_val: -100, exp_sat: 1'b0};
      vecs[5] = '{lane: 1, acc: 1'b1, addr: 2, data: -50,  exp_val: -128, exp_sat: 1'b1};

      nrst        = 1'b0;
      wr_en       = '0;
      wr_mode     = 1'b0;
      wr_addr     = '0;
      wr_data     = '0;
      rd_addr     = '0;
      drain_start = 1'b0;
      drain_clear = 1'b0;
      drain_ready = 1'b0;
      model_reset();

      #2;
      chk("reset busy", int'(busy), 0);
      chk("reset valid", int'(drain_valid), 0);
      chk("reset done", int'(drain_done), 0);
      chk("reset idx", int'(drain_idx), 0);
      check_sat("reset sat");
      check_all_mem("reset mem");
      tick();
      tick();
      nrst = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) begin
         l        = vecs[i].lane;
         wr_en    = '0;
         wr_en[l] = 1'b1;
         wr_mode  = vecs[i].acc;
         wr_addr[l] = ADDR_W'(vecs[i].addr);
         wr_data[l] = DATA_W'(vecs[i].data);
         for (int p = 0; p < RD_PORTS; p++) rd_addr[l][p] = ADDR_W'(vecs[i].addr);
         #1;
         chk("vec same-cycle old", int'($signed(rd_data[l][0])), model[l][vecs[i].addr]);
         model_write(l, vecs[i].acc, vecs[i].addr, vecs[i].data);
         tick();
         wr_en = '0;
         #1;
         for (int p = 0; p < RD_PORTS; p++)
            chk("vec read", int'($signed(rd_data[l][p])), vecs[i].exp_val);
         chk("vec sat", int'(sat_flag[l]), int'(vecs[i].exp_sat));
      end

      for (int c = 0; c < 300; c++) begin
         wr_mode = 1'($urandom_range(0, 1));
         acc     = wr_mode;
         for (int ln = 0; ln < LANES; ln++) begin
            wr_en[ln]   = 1'($urandom_range(0, 1));
            wr_addr[ln] = ADDR_W'($urandom_range(0, DEPTH - 1));
            wr_data[ln] = DATA_W'($urandom_range(0, 255));
            for (int p = 0; p < RD_PORTS; p++)
               rd_addr[ln][p] = ADDR_W'($urandom_range(0, DEPTH - 1));
         end
         #1;
         for (int ln = 0; ln < LANES; ln++)
            for (int p = 0; p < RD_PORTS; p++)
               chk("rand read", int'($signed(rd_data[ln][p])), model[ln][int'(rd_addr[ln][p])]);
         check_sat("rand sat");
         for (int ln = 0; ln < LANES; ln++) begin
            if (wr_en[ln]) begin
               d = int'($signed(wr_data[ln]));
               model_write(ln, acc, int'(wr_addr[ln]), d);
            end
         end
         tick();
      end
      wr_en = '0;
      #1;
      check_all_mem("rand final mem");

      fill_rows(0);
      run_drain(1'b0, 0, 1'b0, "drain ready-high");
      check_sat("sat after drain_start");
      check_all_mem("mem after plain drain");

      run_drain(1'b0, 1, 1'b0, "drain toggle");

      wr_en       = '0;
      wr_en[7]    = 1'b1;
      wr_mode     = 1'b0;
      wr_addr[7]  = '0;
      wr_data[7]  = 8'h55;
      model_write(7, 1'b0, 0, 'h55);
      run_drain(1'b1, 2, 1'b1, "drain clear");
      check_all_mem("mem after clear drain");

      fill_rows(3);
      drain_start = 1'b1;
      drain_clear = 1'b0;
      drain_ready = 1'b1;
      tick();
      drain_start = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 2 * DEPTH && !hit; c++) begin
         if (drain_idx == ADDR_W'(10)) hit = 1'b1;
         else tick();
      end
      chk("reach row 10", int'(drain_idx), 10);
      nrst = 1'b0;
      #1;
      model_reset();
      chk("mid reset busy", int'(busy), 0);
      chk("mid reset valid", int'(drain_valid), 0);
      chk("mid reset done", int'(drain_done), 0);
      chk("mid reset idx", int'(drain_idx), 0);
      check_all_mem("mid reset mem");
      drain_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("no done during reset", int'(drain_done), 0);
      end
      nrst = 1'b1;
      tick();
      chk("no done after reset", int'(drain_done), 0);
      chk("idle after reset", int'(busy), 0);

      fill_rows(10);
      run_drain(1'b0, 0, 1'b0, "drain after reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
